// File: rtl/alu_rr_scheduler.sv
// Two-channel round-robin front end for a shared 4-bit ALU (add/mul/sub/div).
// One operation in flight; results are held until the consumer takes them.
module alu_rr_scheduler #(
    parameter bit         ROUND_ROBIN = 1'b1,
    parameter logic [3:0] DIVZ_QUOT   = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_tag,
    output logic       res_divz,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;

    state_t     state, state_next;
    logic       ptr;
    logic [1:0] op_q;
    logic [3:0] a_q, b_q;
    logic       tag_q;
    logic [3:0] rem_q, quot_q;
    logic [1:0] step_q;

    logic       grant0, grant1, accept;
    logic [1:0] sel_op;
    logic [3:0] sel_a, sel_b;
    logic [4:0] shifted, diff;
    logic       div_ge;
    logic [3:0] rem_next, quot_next;
    logic [7:0] calc_result;

    // The pointer only breaks ties; a lone valid channel always wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (ptr) grant1 = 1'b1;
            else     grant0 = 1'b1;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign sel_op     = grant1 ? req1_op : req0_op;
    assign sel_a      = grant1 ? req1_a  : req0_a;
    assign sel_b      = grant1 ? req1_b  : req0_b;
    assign res_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (sel_op == 2'b11 && sel_b != 4'd0) ? DIV : CALC;
            CALC: state_next = DONE;
            DIV:  if (step_q == 2'd3) state_next = DONE;
            DONE: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divide-by-zero never reaches DIV, so op 11 here is always the zero-divisor case.
    always_comb begin
        calc_result = 8'd0;
        case (op_q)
            2'b00: calc_result = {3'b000, {1'b0, a_q} + {1'b0, b_q}};
            2'b01: calc_result = a_q * b_q;
            2'b10: calc_result = {4'b0000, a_q} - {4'b0000, b_q};
            2'b11: calc_result = {a_q, DIVZ_QUOT};
            default: calc_result = 8'd0;
        endcase
    end

    // Restoring step: quot_q doubles as the dividend shift register.
    assign shifted   = {rem_q, quot_q[3]};
    assign div_ge    = (shifted >= {1'b0, b_q});
    assign diff      = shifted - {1'b0, b_q};
    assign rem_next  = div_ge ? diff[3:0] : shifted[3:0];
    assign quot_next = {quot_q[2:0], div_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            op_q     <= 2'd0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            tag_q    <= 1'b0;
            rem_q    <= 4'd0;
            quot_q   <= 4'd0;
            step_q   <= 2'd0;
            res_data <= 8'd0;
            res_tag  <= 1'b0;
            res_divz <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q   <= sel_op;
                a_q    <= sel_a;
                b_q    <= sel_b;
                tag_q  <= grant1;
                rem_q  <= 4'd0;
                quot_q <= sel_a;
                step_q <= 2'd0;
                if (ROUND_ROBIN) ptr <= ~grant1;
            end
            if (state == CALC) begin
                res_data <= calc_result;
                res_tag  <= tag_q;
                res_divz <= (op_q == 2'b11);
            end
            if (state == DIV) begin
                rem_q  <= rem_next;
                quot_q <= quot_next;
                step_q <= step_q + 2'd1;
                if (step_q == 2'd3) begin
                    res_data <= {rem_next, quot_next};
                    res_tag  <= tag_q;
                    res_divz <= 1'b0;
                end
            end
        end
    end

endmodule
